// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction into a control bundle held in a
// one-entry output register behind valid/ready handshakes, with flush and a transfer counter.
module decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_imm,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic                  out_reg_write,
  output logic                  out_alu_src,
  output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic [2:0]            out_funct3,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      dec_count
);

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  localparam logic [ALU_CTRL_W-1:0] AluAdd   = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] AluSub   = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] AluSll   = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] AluSlt   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] AluSltu  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] AluXor   = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] AluSrl   = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] AluSra   = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] AluOr    = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] AluAnd   = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] AluPassB = ALU_CTRL_W'(10);

  // alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? AluSub : AluAdd;
      3'b001:  alu_op = AluSll;
      3'b010:  alu_op = AluSlt;
      3'b011:  alu_op = AluSltu;
      3'b100:  alu_op = AluXor;
      3'b101:  alu_op = alt ? AluSra : AluSrl;
      3'b110:  alu_op = AluOr;
      default: alu_op = AluAnd;
    endcase
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [XLEN-1:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]       imm_d;
  logic [ALU_CTRL_W-1:0] alu_d;
  logic alu_src_d, reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d, illegal_d;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                                 1'b0}));

  always_comb begin
    imm_d       = '0;
    alu_d       = AluAdd;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    illegal_d   = 1'b0;
    case (opcode)
      OpcOp: begin
        reg_write_d = 1'b1;
        alu_d       = alu_op(f3, in_inst[30]);
        illegal_d   = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OpcOpImm: begin
        imm_d       = imm_i;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_d       = alu_op(f3, (f3 == 3'b101) && in_inst[30]);
        if (f3 == 3'b001 || f3 == 3'b101) illegal_d = !(f7 == 7'h00 || f7 == 7'h20);
      end
      OpcLui: begin
        imm_d       = imm_u;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_d       = AluPassB;
      end
      OpcAuipc: begin
        imm_d       = imm_u;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      OpcJal: begin
        imm_d       = imm_j;
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
      end
      OpcJalr: begin
        imm_d       = imm_i;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        illegal_d   = (f3 != 3'b000);
      end
      OpcBranch: begin
        imm_d     = imm_b;
        alu_d     = AluSub;
        branch_d  = 1'b1;
        illegal_d = (f3 == 3'b010 || f3 == 3'b011);
      end
      OpcLoad: begin
        imm_d       = imm_i;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
        illegal_d   = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OpcStore: begin
        imm_d       = imm_s;
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        illegal_d   = (f3 > 3'b010);
      end
      default: illegal_d = 1'b1;
    endcase
    if (in_inst[11:7] == 5'd0) reg_write_d = 1'b0;
    // Illegal instructions still flow to execute but must have no architectural side effects.
    if (illegal_d) begin
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      jump_d      = 1'b0;
    end
  end

  logic capture;
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      dec_count     <= '0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_alu_src   <= 1'b0;
      out_alu_ctrl  <= '0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
      out_funct3    <= '0;
      out_illegal   <= 1'b0;
    end else begin
      if (out_valid && out_ready) dec_count <= dec_count + CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid     <= 1'b1;
        out_pc        <= in_pc;
        out_imm       <= imm_d;
        out_rs1       <= in_inst[19:15];
        out_rs2       <= in_inst[24:20];
        out_rd        <= in_inst[11:7];
        out_reg_write <= reg_write_d;
        out_alu_src   <= alu_src_d;
        out_alu_ctrl  <= alu_d;
        out_mem_read  <= mem_read_d;
        out_mem_write <= mem_write_d;
        out_branch    <= branch_d;
        out_jump      <= jump_d;
        out_funct3    <= f3;
        out_illegal   <= illegal_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against
// a transaction-level reference model.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        illegal;
  } bundle_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm, dec_count;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write, out_alu_src, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_illegal;
  logic [3:0]  out_alu_ctrl;
  logic [2:0]  out_funct3;
  bundle_t     obs;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic        m_valid;
  bundle_t     m_bundle;
  logic [31:0] m_count;

  decode_stage #(.XLEN(32), .ALU_CTRL_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_alu_src(out_alu_src), .out_alu_ctrl(out_alu_ctrl),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_jump(out_jump), .out_funct3(out_funct3), .out_illegal(out_illegal),
    .dec_count(dec_count)
  );

  assign obs = {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_reg_write, out_alu_src,
                out_alu_ctrl, out_mem_read, out_mem_write, out_branch, out_jump, out_funct3,
                out_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_of(input int f3, input logic alt);
    int tbl [8];
    tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (alt && f3 == 0) return 4'd1;
    if (alt && f3 == 5) return 4'd7;
    return 4'(tbl[f3]);
  endfunction

  // Decode straight from the ISA rules, immediates built arithmetically from bit weights.
  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t b;
    int f3, f7;
    logic legal, wr;
    int imm_i, imm_s, imm_b, imm_j;
    longint imm_u;
    b = '0;
    b.pc = pc; b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.rd = inst[11:7];
    b.funct3 = inst[14:12];
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    imm_i = int'(inst[30:20]) - (inst[31] ? 2048 : 0);
    imm_s = int'(inst[11:7]) + 32 * int'(inst[30:25]) - (inst[31] ? 2048 : 0);
    imm_b = 2 * int'(inst[11:8]) + 32 * int'(inst[30:25]) + 2048 * int'(inst[7])
            - (inst[31] ? 4096 : 0);
    imm_u = longint'(inst[31:12]) * 4096;
    imm_j = 2 * int'(inst[30:21]) + 2048 * int'(inst[20]) + 4096 * int'(inst[19:12])
            - (inst[31] ? 1048576 : 0);
    legal = 1'b1;
    wr = 1'b0;
    case (inst[6:0])
      7'h33: begin
        wr = 1'b1; b.alu_ctrl = alu_of(f3, f7 == 32);
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      7'h13: begin
        wr = 1'b1; b.alu_src = 1'b1; b.imm = 32'(imm_i);
        b.alu_ctrl = alu_of(f3, f3 == 5 && inst[30]);
        if (f3 == 1 || f3 == 5) legal = (f7 == 0 || f7 == 32);
      end
      7'h37: begin wr = 1'b1; b.alu_src = 1'b1; b.imm = 32'(imm_u); b.alu_ctrl = 4'd10; end
      7'h17: begin wr = 1'b1; b.alu_src = 1'b1; b.imm = 32'(imm_u); end
      7'h6F: begin wr = 1'b1; b.jump = 1'b1; b.imm = 32'(imm_j); end
      7'h67: begin
        wr = 1'b1; b.jump = 1'b1; b.alu_src = 1'b1; b.imm = 32'(imm_i); legal = (f3 == 0);
      end
      7'h63: begin
        b.branch = 1'b1; b.alu_ctrl = 4'd1; b.imm = 32'(imm_b); legal = !(f3 == 2 || f3 == 3);
      end
      7'h03: begin
        wr = 1'b1; b.mem_read = 1'b1; b.alu_src = 1'b1; b.imm = 32'(imm_i);
        legal = !(f3 == 3 || f3 >= 6);
      end
      7'h23: begin
        b.mem_write = 1'b1; b.alu_src = 1'b1; b.imm = 32'(imm_s); legal = (f3 <= 2);
      end
      default: legal = 1'b0;
    endcase
    b.reg_write = wr && legal && (inst[11:7] != 5'd0);
    if (!legal) begin
      b.illegal = 1'b1; b.mem_read = 1'b0; b.mem_write = 1'b0; b.branch = 1'b0; b.jump = 1'b0;
    end
    return b;
  endfunction

  // Datapath fields of an illegal bundle carry no meaning; only enables/indices are compared.
  function automatic bundle_t masked(input bundle_t b);
    bundle_t r;
    r = b;
    if (b.illegal) begin r.imm = '0; r.alu_ctrl = '0; r.alu_src = 1'b0; end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_bundle = '0; m_count = '0;
  endtask

  // Called just after a negedge: drive for one cycle, advance the model, return at next negedge.
  task automatic drive_cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                             input logic fl, input logic ordy);
    logic acc;
    in_valid = iv; in_inst = inst; in_pc = pc; flush = fl; out_ready = ordy;
    @(posedge clk);
    if (rst_n) begin
      acc = in_valid && (!m_valid || out_ready) && !flush;
      if (m_valid && out_ready) m_count = m_count + 1;
      if (flush) m_valid = 1'b0;
      else if (acc) begin m_valid = 1'b1; m_bundle = ref_decode(in_inst, in_pc); end
      else if (out_ready) m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    drive_cycle(1'b1, 32'hFFF00293, 32'h1000, 1'b1, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (dec_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", dec_count); end
    n_cmp++; if (obs !== bundle_t'(0)) begin n_err++; $display("FAIL reset_bundle: got %h want 0", obs); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_addi();
    drive_cycle(1'b1, 32'hFFF00293, 32'h8000_0000, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_imm !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", out_imm); end
    n_cmp++; if (out_rd !== 5'd5 || out_alu_ctrl !== 4'd0 || out_alu_src !== 1'b1 || out_reg_write !== 1'b1)
      begin n_err++; $display("FAIL addi_ctrl: got rd=%0d alu=%0d src=%b rw=%b want 5/0/1/1", out_rd, out_alu_ctrl, out_alu_src, out_reg_write); end
    n_cmp++; if (obs !== m_bundle) begin n_err++; $display("FAIL addi_bundle: got %h want %h", obs, m_bundle); end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (dec_count !== 32'd1) begin n_err++; $display("FAIL addi_count: got %0d want 1", dec_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [4];
    logic [3:0]  alus [4];
    logic [31:0] base;
    insts = '{32'h402081B3, 32'h4030D213, 32'h12345337, 32'hFE208EE3};
    alus  = '{4'd1, 4'd7, 4'd10, 4'd1};
    base = m_count;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, insts[i], 32'h2000 + 32'(4 * i), 1'b0, 1'b1);
      n_cmp++; if (out_valid !== 1'b1 || out_alu_ctrl !== alus[i])
        begin n_err++; $display("FAIL b2b_alu[%0d]: got v=%b alu=%0d want 1/%0d", i, out_valid, out_alu_ctrl, alus[i]); end
      n_cmp++; if (obs !== m_bundle) begin n_err++; $display("FAIL b2b_bundle[%0d]: got %h want %h", i, obs, m_bundle); end
      n_cmp++; if (dec_count !== base + 32'(i)) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, dec_count, base + 32'(i)); end
      if (i == 2) begin
        n_cmp++; if (out_imm !== 32'h1234_5000) begin n_err++; $display("FAIL lui_imm: got %h want 12345000", out_imm); end
      end
    end
    n_cmp++; if (out_imm !== 32'hFFFF_FFFC || out_branch !== 1'b1 || out_reg_write !== 1'b0)
      begin n_err++; $display("FAIL beq: got imm=%h br=%b rw=%b want fffffffc/1/0", out_imm, out_branch, out_reg_write); end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    bundle_t exp_a;
    logic [31:0] cnt0;
    drive_cycle(1'b1, 32'h00700093, 32'h3000, 1'b0, 1'b1);
    exp_a = ref_decode(32'h00700093, 32'h3000);
    cnt0 = m_count;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 32'h0041A103, 32'h3004, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || obs !== exp_a) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, obs, exp_a); end
      n_cmp++; if (dec_count !== cnt0) begin n_err++; $display("FAIL bp_count[%0d]: got %0d want %0d", i, dec_count, cnt0); end
    end
    drive_cycle(1'b1, 32'h0041A103, 32'h3004, 1'b0, 1'b1);
    n_cmp++; if (obs !== ref_decode(32'h0041A103, 32'h3004) || dec_count !== cnt0 + 1)
      begin n_err++; $display("FAIL bp_resume: got %h cnt=%0d want next bundle cnt=%0d", obs, dec_count, cnt0 + 1); end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || dec_count !== cnt0 + 2)
      begin n_err++; $display("FAIL bp_drain: got v=%b cnt=%0d want 0/%0d", out_valid, dec_count, cnt0 + 2); end
  endtask

  task automatic test_flush();
    logic [31:0] cnt0;
    drive_cycle(1'b1, 32'h00700093, 32'h4000, 1'b0, 1'b1);
    cnt0 = m_count;
    in_valid = 1'b1; in_inst = 32'h00500313; flush = 1'b1; out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    drive_cycle(1'b1, 32'h00500313, 32'h4004, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || dec_count !== cnt0)
      begin n_err++; $display("FAIL flush_drop: got v=%b cnt=%0d want 0/%0d", out_valid, dec_count, cnt0); end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || dec_count !== cnt0)
      begin n_err++; $display("FAIL flush_after: got v=%b cnt=%0d want 0/%0d", out_valid, dec_count, cnt0); end
  endtask

  task automatic test_illegal();
    logic [31:0] insts [3];
    logic        ills [3];
    insts = '{32'h0000007F, 32'h00100013, 32'h000110E7};
    ills  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, insts[i], 32'h5000 + 32'(4 * i), 1'b0, 1'b1);
      n_cmp++; if (out_illegal !== ills[i] || out_reg_write !== 1'b0 || out_mem_read !== 1'b0 ||
                   out_mem_write !== 1'b0 || out_branch !== 1'b0 || out_jump !== 1'b0)
        begin n_err++; $display("FAIL illegal[%0d]: got ill=%b rw=%b mr=%b mw=%b br=%b j=%b want ill=%b enables 0",
                                i, out_illegal, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, ills[i]); end
      n_cmp++; if (masked(obs) !== masked(m_bundle)) begin n_err++; $display("FAIL illegal_bundle[%0d]: got %h want %h", i, obs, m_bundle); end
    end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midstream();
    drive_cycle(1'b1, 32'h00700093, 32'h6000, 1'b0, 1'b0);
    in_valid = 1'b1; in_inst = 32'h00A00113; in_pc = 32'h6004; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || dec_count !== 32'd0 || obs !== bundle_t'(0))
      begin n_err++; $display("FAIL midreset: got v=%b cnt=%0d b=%h want all 0", out_valid, dec_count, obs); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 32'h00A00113, 32'h6004, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || obs !== ref_decode(32'h00A00113, 32'h6004))
      begin n_err++; $display("FAIL midreset_capture: got v=%b b=%h want first capture", out_valid, obs); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] inst;
    logic        iv, ordy, fl;
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};
    for (int c = 0; c < 800; c++) begin
      inst = $urandom;
      inst[6:0] = ops[$urandom_range(0, 9)];
      if ((inst[6:0] == 7'h13 || inst[6:0] == 7'h33) && $urandom_range(0, 3) != 0)
        inst[31:25] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
      iv   = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      fl   = $urandom_range(0, 15) == 0;
      drive_cycle(iv, inst, $urandom & 32'hFFFF_FFFC, fl, ordy);
      n_cmp++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, m_valid); end
      n_cmp++; if (dec_count !== m_count) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, dec_count, m_count); end
      n_cmp++; if (in_ready !== (!m_valid || out_ready)) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", c, in_ready, !m_valid || out_ready); end
      if (m_valid) begin
        n_cmp++; if (masked(obs) !== masked(m_bundle))
          begin n_err++; $display("FAIL rnd_bundle@%0d: got %h want %h", c, obs, m_bundle); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
